// File: rtl/wback_regfile.sv
// Y86-64 writeback stage and architectural register file: commits W-stage results,
// serves decode/debug reads, and keeps the sticky processor status and retired count.

module wback_rdport #(
    parameter int WIDTH = 64,
    parameter int NREGS = 15
) (
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    input  logic [3:0]                  sel,
    output logic [WIDTH-1:0]            val
);
    // RNONE and out-of-range IDs fall through to zero
    always_comb begin
        val = '0;
        for (int i = 0; i < NREGS; i++)
            if (sel == 4'(i) && sel != 4'hF) val = regs[i];
    end
endmodule

module wback_regfile #(
    parameter int WIDTH = 64,
    parameter int NREGS = 15,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [WIDTH-1:0] W_valM,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [WIDTH-1:0] d_rvalA,
    output logic [WIDTH-1:0] d_rvalB,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_val,
    output logic [3:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    localparam logic [3:0] STAT_BUB = 4'd0;
    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam int         NRD      = 3;

    typedef struct packed {
        logic [3:0]       stat;
        logic [3:0]       icode;
        logic [3:0]       dst_e;
        logic [3:0]       dst_m;
        logic [WIDTH-1:0] val_e;
        logic [WIDTH-1:0] val_m;
    } wreq_t;

    typedef enum logic {S_RUN, S_HALT} state_t;

    wreq_t                         w;
    state_t                        state, state_nxt;
    logic [NREGS-1:0][WIDTH-1:0]   regs;
    logic [3:0]                    stat_q;
    logic                          fault;
    logic [3:0]                    fault_stat;
    logic                          we;
    logic [NRD-1:0][3:0]           rd_sel;
    logic [NRD-1:0][WIDTH-1:0]     rd_val;

    assign w = '{stat: W_stat, icode: W_icode, dst_e: W_dstE, dst_m: W_dstM,
                 val_e: W_valE, val_m: W_valM};

    // Read ports: 0 = srcA, 1 = srcB, 2 = debug; no write-through by design
    assign rd_sel = {dbg_sel, d_srcB, d_srcA};
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        wback_rdport #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rd (
            .regs (regs),
            .sel  (rd_sel[g]),
            .val  (rd_val[g])
        );
    end
    assign d_rvalA = rd_val[0];
    assign d_rvalB = rd_val[1];
    assign dbg_val = rd_val[2];

    // A halt icode arriving as AOK is promoted to HLT; unknown codes become INS
    always_comb begin
        fault      = 1'b0;
        fault_stat = STAT_INS;
        case (w.stat)
            STAT_BUB: ;
            STAT_AOK: if (w.icode == 4'h0) begin
                fault      = 1'b1;
                fault_stat = STAT_HLT;
            end
            STAT_HLT, STAT_ADR, STAT_INS: begin
                fault      = 1'b1;
                fault_stat = w.stat;
            end
            default: begin
                fault      = 1'b1;
                fault_stat = STAT_INS;
            end
        endcase
    end

    assign we = (state == S_RUN) && (w.stat == STAT_AOK) && (w.icode != 4'h0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (fault) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        halted = (state == S_HALT);
    end

    // valM is applied after valE so it wins a same-register collision
    always_ff @(posedge clk) begin
        if (rst) begin
            regs        <= '0;
            stat_q      <= STAT_AOK;
            instr_count <= '0;
        end else begin
            if (we) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (w.dst_e == 4'(i) && w.dst_e != RNONE) regs[i] <= w.val_e;
                    if (w.dst_m == 4'(i) && w.dst_m != RNONE) regs[i] <= w.val_m;
                end
                instr_count <= instr_count + CNT_W'(1);
            end
            if (state == S_RUN && fault) stat_q <= fault_stat;
        end
    end

    assign Stat = stat_q;
endmodule

// File: tb/tb_wback_regfile.sv
// Bench for wback_regfile: directed scenarios plus randomized traffic against a
// behavioural register-file/status model.

module tb_wback_regfile;
    localparam int WIDTH = 64;
    localparam int NREGS = 15;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       W_stat = '0, W_icode = '0, W_dstE = 4'hF, W_dstM = 4'hF;
    logic [63:0]      W_valE = '0, W_valM = '0;
    logic [3:0]       d_srcA = '0, d_srcB = '0, dbg_sel = '0;
    logic [63:0]      d_rvalA, d_rvalB, dbg_val;
    logic [3:0]       Stat;
    logic             halted;
    logic [63:0]      instr_count;

    wback_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val),
        .Stat(Stat), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] m_reg [NREGS];
    logic [3:0]  m_stat = 4'd1;
    logic        m_halt = 1'b0;
    logic [63:0] m_cnt  = '0;
    logic        m_valid = 1'b0;
    logic [63:0] pre_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_rd(input logic [3:0] id);
        return (int'(id) < NREGS) ? m_reg[id] : 64'h0;
    endfunction

    // Architectural rules applied to whatever was presented at the edge
    task automatic m_step();
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = '0;
            m_stat = 4'd1; m_halt = 1'b0; m_cnt = '0;
        end else if (!m_halt) begin
            if (W_stat == 4'd1 && W_icode != 4'd0) begin
                if (int'(W_dstE) < NREGS) m_reg[W_dstE] = W_valE;
                if (int'(W_dstM) < NREGS) m_reg[W_dstM] = W_valM;
                m_cnt = m_cnt + 1;
            end else if (W_stat == 4'd1) begin
                m_halt = 1'b1; m_stat = 4'd2;
            end else if (W_stat != 4'd0) begin
                m_halt = 1'b1; m_stat = (W_stat <= 4'd4) ? W_stat : 4'd4;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dg);
        rst = r; W_stat = st; W_icode = ic; W_dstE = de; W_valE = ve;
        W_dstM = dm; W_valM = vm; d_srcA = sa; d_srcB = sb; dbg_sel = dg;
        #1;
        pre_a = d_rvalA;
        if (m_valid) begin
            chk("rvalA", d_rvalA, m_rd(sa));
            chk("rvalB", d_rvalB, m_rd(sb));
            chk("dbg",   dbg_val, m_rd(dg));
        end
        @(posedge clk);
        m_step();
        m_valid = 1'b1;
        #1;
        chk("Stat",   64'(Stat),   64'(m_stat));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("count",  instr_count, m_cnt);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] de,
                      input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        cyc(1'b0, st, ic, de, ve, dm, vm, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    task automatic peek(input logic [3:0] id, input logic [63:0] exp, input string tag);
        rst = 1'b0; W_stat = 4'd0; dbg_sel = id;
        #1;
        chk(tag, dbg_val, exp);
    endtask

    task automatic do_reset();
        cyc(1'b1, 4'd0, 4'd1, 4'hF, '0, 4'hF, '0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_stat", 64'(Stat), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", instr_count, 64'd0);
        peek(4'd0, 64'h0, "rst_reg0");

        // Two AOK writes
        wr(4'd1, 4'd3, 4'd0, 64'h10, 4'hF, 64'h0);
        wr(4'd1, 4'd3, 4'd3, 64'hDEAD, 4'hF, 64'h0);
        peek(4'd0, 64'h10, "aok_reg0");
        peek(4'd3, 64'hDEAD, "aok_reg3");
        chk("aok_count", instr_count, 64'd2);
        chk("aok_stat", 64'(Stat), 64'd1);

        // Collision: valM wins; then valE alone
        wr(4'd1, 4'd11, 4'd4, 64'h100, 4'd4, 64'h55);
        peek(4'd4, 64'h55, "coll_m_wins");
        wr(4'd1, 4'd11, 4'd4, 64'h100, 4'hF, 64'h0);
        peek(4'd4, 64'h100, "coll_e_only");

        // Bubble writes nothing; AOK with RNONE only counts
        wr(4'd0, 4'd3, 4'd2, 64'hFF, 4'hF, 64'h0);
        chk("bub_count", instr_count, 64'd4);
        wr(4'd1, 4'd1, 4'hF, 64'h1234, 4'hF, 64'h5678);
        peek(4'd2, 64'h0, "bub_reg2");
        chk("rnone_count", instr_count, 64'd5);

        // Read-during-write returns old value
        wr(4'd1, 4'd3, 4'd6, 64'h1, 4'hF, 64'h0);
        cyc(1'b0, 4'd1, 4'd3, 4'd6, 64'h2, 4'hF, 64'h0, 4'd6, 4'd0, 4'd0);
        chk("rdw_old", pre_a, 64'h1);
        #1;
        chk("rdw_new", d_rvalA, 64'h2);
        d_srcA = 4'hF;
        #1;
        chk("rd_rnone", d_rvalA, 64'h0);

        // Fault: ADR suppresses write, halts, freezes everything
        wr(4'd3, 4'd5, 4'hF, 64'h0, 4'd5, 64'h77);
        chk("adr_stat", 64'(Stat), 64'd3);
        chk("adr_halted", 64'(halted), 64'd1);
        peek(4'd5, 64'h0, "adr_reg5");
        wr(4'd1, 4'd3, 4'd1, 64'h99, 4'hF, 64'h0);
        wr(4'd2, 4'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        peek(4'd1, 64'h0, "halt_reg1");
        chk("halt_count", instr_count, 64'd7);
        chk("halt_stat", 64'(Stat), 64'd3);

        // Reset mid-halt discards a simultaneous write
        cyc(1'b1, 4'd1, 4'd3, 4'd2, 64'h42, 4'd9, 64'h43, 4'd0, 4'd0, 4'd0);
        chk("rst2_stat", 64'(Stat), 64'd1);
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_count", instr_count, 64'd0);
        for (int i = 0; i < NREGS; i++) peek(4'(i), 64'h0, "rst2_reg");

        // Halt icode with AOK status, then an undefined status code
        wr(4'd1, 4'd0, 4'd7, 64'h5, 4'hF, 64'h0);
        chk("hlt_icode_stat", 64'(Stat), 64'd2);
        peek(4'd7, 64'h0, "hlt_icode_reg7");
        do_reset();
        wr(4'd9, 4'd3, 4'd7, 64'h5, 4'hF, 64'h0);
        chk("undef_stat", 64'(Stat), 64'd4);
        chk("undef_halted", 64'(halted), 64'd1);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic       r;
            logic [3:0] st;
            int         k;
            r = m_halt ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
            k = int'($urandom_range(0, 99));
            if (k < 75)      st = 4'd1;
            else if (k < 92) st = 4'd0;
            else if (k < 97) st = 4'($urandom_range(2, 4));
            else             st = 4'($urandom_range(5, 15));
            cyc(r, st, ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                4'($urandom_range(0, 15)), {$urandom, $urandom},
                4'($urandom_range(0, 15)), {$urandom, $urandom},
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wback_regfile.md
Name: wback_regfile

Overview:
- Writeback stage and architectural register file of the Y86-64 pipeline.
- Consumes the W-stage pipeline register outputs (W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM) and commits results to the 15 program registers.
- Serves decode-stage reads and maintains the sticky processor status and a retired-instruction counter.
- Sits after the M->W pipeline register and feeds decode and the pipeline control logic.

Parameters:
- WIDTH, 64, data width of registers and values.
- NREGS, 15, number of program registers (IDs 0..14); ID 4'hF is RNONE.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- W_stat  input  4  status of the instruction in W (0=BUB, 1=AOK, 2=HLT, 3=ADR, 4=INS).
- W_icode  input  4  icode of the instruction in W.
- W_valE  input  WIDTH  ALU result to write.
- W_valM  input  WIDTH  memory result to write.
- W_dstE  input  4  destination register for valE (F = none).
- W_dstM  input  4  destination register for valM (F = none).
- d_srcA  input  4  decode read address A.
- d_srcB  input  4  decode read address B.
- d_rvalA  output  WIDTH  register-file value for srcA.
- d_rvalB  output  WIDTH  register-file value for srcB.
- dbg_sel  input  4  debug read address.
- dbg_val  output  WIDTH  debug read value.
- Stat  output  4  architectural processor status.
- halted  output  1  high once Stat != AOK.
- instr_count  output  CNT_W  count of retired non-bubble AOK instructions.

Behaviour:
- Clock and reset: one clock domain (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at posedge):
  - All 15 registers cleared to 0.
  - Stat=1 (AOK), halted=0, instr_count=0.
  - rst overrides any same-cycle write.
  - Reset mid-run clears the halted state.
- Reads:
  - d_rvalA, d_rvalB and dbg_val are combinational from the array.
  - Source ID F, or any ID >= NREGS, reads 0.
  - No internal write-through: a read in the same cycle as a write returns the old value. The forwarding unit supplies W_valE/W_valM.
- Write enable: commit at posedge only when not halted AND W_stat==AOK (1).
  - Bubbles (0) write nothing and do not count.
  - HLT/ADR/INS write nothing.
- valE write: if the write enable is set and W_dstE != F and W_dstE < NREGS, reg[W_dstE] <= W_valE.
- valM write: if the write enable is set and W_dstM != F and W_dstM < NREGS, reg[W_dstM] <= W_valM.
- Collision (W_dstE == W_dstM, both valid): valM wins (popq %rsp semantics).
- Status FSM, two states:
  - RUN (halted=0, Stat=AOK):
    - W_stat in {HLT, ADR, INS} -> go to HALT and latch Stat <= W_stat in that same posedge.
    - W_stat in {BUB, AOK} -> stay in RUN.
    - Undefined codes 5..15 -> HALT with Stat=INS.
  - HALT (halted=1): sticky. Stat frozen, no further register writes, counter frozen, regardless of W inputs. Exit only via rst.
  - halted and Stat are registered outputs: they change the cycle after the faulting instruction is in W.
- Counter: instr_count increments by 1 at each posedge with the write enable set. The counter wraps modulo 2^CNT_W with no saturation.
- W_icode:
  - Has no effect on writes; dstE/dstM already encode intent.
  - Reserved: a one-cycle HALT entry also occurs when W_icode == 0 (halt) with W_stat == AOK, treated as Stat=HLT. Register writes in that cycle are still suppressed.
- Latency: write to read-visible is 1 cycle, i.e. the value is visible on d_rval* after the posedge that commits it.

Test Plan:
- Reset then AOK instructions:
  - Stimulus: irmovq-style W_dstE=0, W_valE=0x10, W_dstM=F; next cycle W_dstE=3, W_valE=0xDEAD.
  - Required: rval(0)=0x10, rval(3)=0xDEAD, instr_count=2, Stat=1.
- Collision:
  - Stimulus: W_stat=AOK, W_dstE=4, W_valE=0x100, W_dstM=4, W_valM=0x55.
  - Required: reg4=0x55.
  - Same stimulus with W_dstM=F: reg4=0x100.
- Bubble and RNONE:
  - Stimulus: W_stat=0 with W_dstE=2, W_valE=0xFF; then AOK with both dst=F.
  - Required: reg2 unchanged (0), instr_count +1 only for the AOK cycle.
- Fault:
  - Stimulus: W_stat=ADR, W_dstM=5, W_valM=0x77.
  - Required: reg5 unchanged, next cycle Stat=3, halted=1.
  - Subsequent AOK write to reg1 is ignored and instr_count stays frozen.
- Read-during-write:
  - Stimulus: d_srcA=6 while writing reg6 (old 0x1) with 0x2.
  - Required: d_rvalA=0x1 that cycle, 0x2 the next.
  - d_srcA=F reads 0.
- Reset mid-halt:
  - Stimulus: assert rst for 1 cycle after the HLT state.
  - Required: Stat=1, halted=0, all regs 0, instr_count=0.
  - A write presented together with rst is discarded.
